// File: rtl/page_choose_ctrl_pkg.sv
// Shared constants for the game-start menu: difficulty codes, FSM encoding,
// button lane indices and the option register layout.
package page_choose_ctrl_pkg;

    localparam logic [1:0] HARD_EASY   = 2'd0;
    localparam logic [1:0] HARD_NORMAL = 2'd1;
    localparam logic [1:0] HARD_HARD   = 2'd2;

    localparam int NUM_BTN   = 5;
    localparam int BTN_ENTER = 0;
    localparam int BTN_UP    = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_LEFT  = 3;
    localparam int BTN_RIGHT = 4;

    typedef enum logic [1:0] {
        ST_SEL = 2'd0,
        ST_REQ = 2'd1,
        ST_RUN = 2'd2
    } state_t;

    // Menu selections shown by the page renderer and latched for the game core.
    typedef struct packed {
        logic       up;     // 0 = difficulty row, 1 = speed row
        logic [1:0] hard;
        logic       speed;
    } opt_t;

    // Cyclic difficulty step over the three legal codes; fwd=1 is "right".
    function automatic logic [1:0] hard_step(input logic [1:0] h, input logic fwd);
        logic [1:0] r;
        case (h)
            HARD_EASY:   r = fwd ? HARD_NORMAL : HARD_HARD;
            HARD_NORMAL: r = fwd ? HARD_HARD   : HARD_EASY;
            HARD_HARD:   r = fwd ? HARD_EASY   : HARD_NORMAL;
            default:     r = HARD_EASY;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/page_choose_ctrl_btn_debounce.sv
// One push-button lane: 2-FF synchroniser, stability counter, and a
// registered one-cycle pulse on the debounced rising edge.
module btn_debounce #(
    parameter int DEB_CNT = 50000
) (
    input  logic clk_25MHz,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam logic [15:0] CNT_LAST = 16'(DEB_CNT - 1);

    logic [1:0]  sync_q;
    logic        deb_q;
    logic [15:0] cnt_q;

    // bring the raw level into the clock domain
    always_ff @(posedge clk_25MHz or negedge rst) begin
        if (!rst) sync_q <= '0;
        else      sync_q <= {sync_q[0], btn_raw};
    end

    // accept a new level only after DEB_CNT consecutive differing samples;
    // press fires only for the 0->1 flip, so releases are silent
    always_ff @(posedge clk_25MHz or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            deb_q <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_q[1] == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
                deb_q <= sync_q[1];
                press <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

endmodule

// File: rtl/page_choose_ctrl.sv
// Start-menu controller: debounces five buttons, walks the cursor and option
// registers while the menu is open, and hands the configuration to the game
// core with a start_req/start_ack handshake.
module page_choose_ctrl
    import page_choose_ctrl_pkg::*;
#(
    parameter int DEB_CNT = 50000
) (
    input  logic       clk_25MHz,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_enter,
    input  logic       start_ack,
    input  logic       menu_return,
    output logic       up,
    output logic [1:0] hard,
    output logic       speed,
    output logic       start_req,
    output logic       menu_active
);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] press;

    state_t state_q, state_n;
    opt_t   opt_q, opt_n;

    assign btn_raw[BTN_ENTER] = btn_enter;
    assign btn_raw[BTN_UP]    = btn_up;
    assign btn_raw[BTN_DOWN]  = btn_down;
    assign btn_raw[BTN_LEFT]  = btn_left;
    assign btn_raw[BTN_RIGHT] = btn_right;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
            .clk_25MHz (clk_25MHz),
            .rst       (rst),
            .btn_raw   (btn_raw[i]),
            .press     (press[i])
        );
    end

    // next state and options; at most one event is used per cycle in SEL,
    // and anything arriving in REQ/RUN is simply dropped
    always_comb begin
        state_n = state_q;
        opt_n   = opt_q;
        case (state_q)
            ST_SEL: begin
                if (press[BTN_ENTER]) begin
                    state_n = ST_REQ;
                end else if (press[BTN_UP]) begin
                    opt_n.up = 1'b0;
                end else if (press[BTN_DOWN]) begin
                    opt_n.up = 1'b1;
                end else if (press[BTN_LEFT]) begin
                    if (opt_q.up) opt_n.speed = ~opt_q.speed;
                    else          opt_n.hard  = hard_step(opt_q.hard, 1'b0);
                end else if (press[BTN_RIGHT]) begin
                    if (opt_q.up) opt_n.speed = ~opt_q.speed;
                    else          opt_n.hard  = hard_step(opt_q.hard, 1'b1);
                end
            end
            ST_REQ: begin
                if (start_ack) state_n = ST_RUN;
            end
            ST_RUN: begin
                if (menu_return) begin
                    state_n  = ST_SEL;
                    opt_n.up = 1'b0;
                end
            end
            default: state_n = ST_SEL;
        endcase
    end

    // state, options and handshake flags are all flops so outputs never
    // see a combinational path from the inputs
    always_ff @(posedge clk_25MHz or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_SEL;
            opt_q       <= '{up: 1'b0, hard: HARD_EASY, speed: 1'b0};
            start_req   <= 1'b0;
            menu_active <= 1'b1;
        end else begin
            state_q     <= state_n;
            opt_q       <= opt_n;
            start_req   <= (state_n == ST_REQ);
            menu_active <= (state_n == ST_SEL);
        end
    end

    assign up    = opt_q.up;
    assign hard  = opt_q.hard;
    assign speed = opt_q.speed;

endmodule

// File: tb/tb_page_choose_ctrl.sv
// Bench for page_choose_ctrl with DEB_CNT=4: a directed table of menu
// actions, hand-written timing/reset sequences, then random button noise,
// all shadowed every cycle by a window-based behavioural model.
module tb_page_choose_ctrl;

    localparam int DEB = 4;
    // button bit positions in b[]
    localparam logic [4:0] PE = 5'b00001, PU = 5'b00010, PD = 5'b00100,
                           PL = 5'b01000, PR = 5'b10000, P0 = 5'b00000;

    logic       clk_25MHz = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] b = '0;
    logic       start_ack = 1'b0, menu_return = 1'b0;
    logic       up, speed, start_req, menu_active;
    logic [1:0] hard;

    int n_chk = 0, n_fail = 0;
    bit mdl_on = 0;

    page_choose_ctrl #(.DEB_CNT(DEB)) dut (
        .clk_25MHz   (clk_25MHz),
        .rst         (rst),
        .btn_up      (b[1]),
        .btn_down    (b[2]),
        .btn_left    (b[3]),
        .btn_right   (b[4]),
        .btn_enter   (b[0]),
        .start_ack   (start_ack),
        .menu_return (menu_return),
        .up          (up),
        .hard        (hard),
        .speed       (speed),
        .start_req   (start_req),
        .menu_active (menu_active)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_25MHz);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    // A level is accepted once the last DEB synchronised samples (raw samples
    // from two edges back) all disagree with the accepted level; the press
    // is acted on one edge after acceptance.
    int       m_state;   // 0 menu, 1 requesting, 2 running
    bit       m_up, m_speed;
    int       m_hard;
    bit [15:0] hist [5];
    bit [4:0] deb, pend;

    always @(posedge clk_25MHz or negedge rst) begin
        bit [4:0] ev;
        bit all_diff;
        if (!rst) begin
            m_state = 0; m_up = 0; m_hard = 0; m_speed = 0;
            deb = '0; pend = '0;
            for (int i = 0; i < 5; i++) hist[i] = '0;
        end else begin
            ev = pend;
            for (int i = 0; i < 5; i++) begin
                hist[i] = {hist[i][14:0], b[i]};
                all_diff = 1;
                for (int k = 2; k <= DEB + 1; k++)
                    if (hist[i][k] == deb[i]) all_diff = 0;
                pend[i] = 0;
                if (all_diff) begin
                    deb[i]  = ~deb[i];
                    pend[i] = deb[i];
                end
            end
            if (m_state == 0) begin
                if (ev[0])      m_state = 1;
                else if (ev[1]) m_up = 0;
                else if (ev[2]) m_up = 1;
                else if (ev[3]) begin if (m_up) m_speed = ~m_speed; else m_hard = (m_hard + 2) % 3; end
                else if (ev[4]) begin if (m_up) m_speed = ~m_speed; else m_hard = (m_hard + 1) % 3; end
            end else if (m_state == 1) begin
                if (start_ack) m_state = 2;
            end else begin
                if (menu_return) begin m_state = 0; m_up = 0; end
            end
        end
    end

    always @(negedge clk_25MHz) begin
        if (mdl_on) begin
            check("mdl_up",   {7'd0, up},          {7'd0, m_up});
            check("mdl_hard", {6'd0, hard},        8'(m_hard));
            check("mdl_spd",  {7'd0, speed},       {7'd0, m_speed});
            check("mdl_req",  {7'd0, start_req},   {7'd0, m_state == 1});
            check("mdl_menu", {7'd0, menu_active}, {7'd0, m_state == 0});
        end
    end

    // ---------------- directed table ----------------
    typedef struct {
        logic [4:0] btn;
        logic       ack, ret;
        logic       e_up;
        logic [1:0] e_hard;
        logic       e_speed, e_req, e_menu;
    } vec_t;

    vec_t vt [17];

    task automatic check_outs(input string nm, input logic eu, input logic [1:0] eh,
                              input logic es, input logic er, input logic em);
        check({nm, ".up"},   {7'd0, up},          {7'd0, eu});
        check({nm, ".hard"}, {6'd0, hard},        {6'd0, eh});
        check({nm, ".spd"},  {7'd0, speed},       {7'd0, es});
        check({nm, ".req"},  {7'd0, start_req},   {7'd0, er});
        check({nm, ".menu"}, {7'd0, menu_active}, {7'd0, em});
    endtask

    initial begin
        vt[0]  = '{PR, 0, 0, 0, 2'd1, 0, 0, 1};
        vt[1]  = '{PR, 0, 0, 0, 2'd2, 0, 0, 1};
        vt[2]  = '{PR, 0, 0, 0, 2'd0, 0, 0, 1};
        vt[3]  = '{PD, 0, 0, 1, 2'd0, 0, 0, 1};
        vt[4]  = '{PL, 0, 0, 1, 2'd0, 1, 0, 1};
        vt[5]  = '{PD, 0, 0, 1, 2'd0, 1, 0, 1};
        vt[6]  = '{PU, 0, 0, 0, 2'd0, 1, 0, 1};
        vt[7]  = '{PL, 0, 0, 0, 2'd2, 1, 0, 1};
        vt[8]  = '{PL, 0, 0, 0, 2'd1, 1, 0, 1};
        vt[9]  = '{PE, 0, 0, 0, 2'd1, 1, 1, 0};
        vt[10] = '{PR, 0, 0, 0, 2'd1, 1, 1, 0};
        vt[11] = '{P0, 1, 0, 0, 2'd1, 1, 0, 0};
        vt[12] = '{PL, 0, 0, 0, 2'd1, 1, 0, 0};
        vt[13] = '{P0, 0, 1, 0, 2'd1, 1, 0, 1};
        vt[14] = '{PD, 0, 0, 1, 2'd1, 1, 0, 1};
        vt[15] = '{P0, 0, 1, 1, 2'd1, 1, 0, 1};
        vt[16] = '{P0, 1, 0, 1, 2'd1, 1, 0, 1};

        // reset state
        cyc(3);
        check_outs("reset", 0, 2'd0, 0, 0, 1);
        rst = 1'b1;
        mdl_on = 1;
        cyc(2);
        check_outs("post_reset", 0, 2'd0, 0, 0, 1);

        for (int i = 0; i < 17; i++) begin
            if (vt[i].btn != P0) begin
                b = vt[i].btn;
                cyc(DEB + 3);
                b = '0;
                cyc(DEB + 4);
            end
            if (vt[i].ack) begin start_ack = 1; cyc(1); start_ack = 0; cyc(1); end
            if (vt[i].ret) begin menu_return = 1; cyc(1); menu_return = 0; cyc(1); end
            check_outs($sformatf("row%0d", i), vt[i].e_up, vt[i].e_hard,
                       vt[i].e_speed, vt[i].e_req, vt[i].e_menu);
        end

        // glitch shorter than the window: on the speed row, right would toggle
        b = PR; cyc(DEB - 1); b = '0; cyc(10);
        check_outs("glitch", 1, 2'd1, 1, 0, 1);

        // enter+right together: enter wins, request rises exactly at edge DEB+3
        b = PE | PR;
        cyc(DEB + 2);
        check("enter_e6.req", {7'd0, start_req}, 8'd0);
        cyc(1);
        check_outs("enter_e7", 1, 2'd1, 1, 1, 0);
        b = PR;  // right stays held into the reset below
        cyc(2);

        // reset while requesting with a button held
        rst = 1'b0;
        #1;
        check_outs("rst_async", 0, 2'd0, 0, 0, 1);
        cyc(2);
        rst = 1'b1;
        cyc(DEB + 2);
        check("rst_hold_e6.hard", {6'd0, hard}, 8'd0);
        cyc(1);
        check("rst_hold_e7.hard", {6'd0, hard}, 8'd1);
        b = '0;
        cyc(10);

        // random noise on every input, occasional resets
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 5; i++)
                if ($urandom_range(0, 5) == 0) b[i] = ~b[i];
            start_ack   = ($urandom_range(0, 7) == 0);
            menu_return = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b0;
                cyc(1);
                rst = 1'b1;
            end
            cyc(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/page_choose_ctrl.md
PAGE_CHOOSE_CTRL -- requirements
Module: page_choose_ctrl

Interface
REQ-001 Parameter: DEB_CNT, default 50000, number of consecutive stable cycles before a button level is accepted (2 ms at 25 MHz).
REQ-002 clk_25MHz  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 btn_up, btn_down, btn_left, btn_right, btn_enter  input  1 each  raw, unsynchronised push-buttons, active-high.
REQ-005 start_ack  input  1  game core accepts the latched configuration.
REQ-006 menu_return  input  1  single-cycle request to reopen the menu.
REQ-007 up  output  1  cursor row to the page renderer: 0 = difficulty row, 1 = speed row.
REQ-008 hard  output  2  difficulty code: 0 easy, 1 normal, 2 hard; 3 never driven.
REQ-009 speed  output  1  speed option: 0 normal, 1 fast.
REQ-010 start_req  output  1  configuration-valid request, held until acknowledged.
REQ-011 menu_active  output  1  high while the menu accepts navigation input.

Function
REQ-012 Each button SHALL pass through a 2-FF synchroniser, then a 16-bit stability counter.
REQ-013 The stability counter SHALL clear whenever the synchronised level equals the debounced level.
REQ-014 The debounced level SHALL flip when the synchronised level has differed from it for DEB_CNT consecutive cycles.
REQ-015 A press event SHALL be a one-cycle pulse on the debounced rising edge; releases generate no event.
REQ-016 A raw press held stable SHALL change up/hard/speed/start_req at rising edge DEB_CNT+3 after the raw level is first sampled high.
REQ-017 FSM states: SEL, REQ, RUN.
  - SEL: menu_active=1, start_req=0.
  - REQ: start_req=1, menu_active=0.
  - RUN: both 0.
REQ-018 In SEL, only one event SHALL be consumed per cycle, with priority enter > up > down > left > right; lower-priority simultaneous events are discarded.
REQ-019 In SEL, up event SHALL set up=0 and down event SHALL set up=1; both are idempotent at the row limits (no wrap).
REQ-020 In SEL with up=0, right SHALL step hard 0->1->2->0 and left SHALL step hard 0->2->1->0 (wrap-around).
REQ-021 In SEL with up=1, left or right SHALL toggle speed.
REQ-022 An enter event in SEL SHALL move the FSM to REQ; up, hard and speed are frozen from that edge.
REQ-023 In REQ, start_ack=1 SHALL move the FSM to RUN on the same edge; start_req SHALL deassert that edge.
REQ-024 In RUN, menu_return=1 SHALL return the FSM to SEL with up cleared to 0; hard and speed are retained.
REQ-025 Button events in REQ and RUN SHALL be discarded; they are not queued.
REQ-026 start_ack outside REQ and menu_return outside RUN SHALL be ignored.
REQ-027 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-028 rst low SHALL asynchronously force: FSM=SEL, up=0, hard=0, speed=0, start_req=0, menu_active=1.
REQ-029 rst low SHALL also clear all synchronisers, debounced levels and counters to 0.
REQ-030 Reset asserted mid-press SHALL discard the press; a button still held at reset release SHALL generate an event only after a full DEB_CNT stable window.

Structure
REQ-031 A shared package SHALL hold the difficulty constants HARD_EASY=2'd0, HARD_NORMAL=2'd1, HARD_HARD=2'd2 and the FSM state encoding; page_choose imports the same constants.
REQ-032 Debounce and edge detection SHALL live in one sub-module, btn_debounce (parameter DEB_CNT; ports clk_25MHz, rst, btn_raw, press), instantiated five times.
REQ-033 The FSM and option registers SHALL reside in page_choose_ctrl.

Verification (DEB_CNT=4)
REQ-034 Reset, then press right three times on row 0 -> hard sequence 1, 2, 0; speed stays 0; up stays 0.
REQ-035 Press down, then left -> up=1, speed=1, hard unchanged; a further down -> up stays 1.
REQ-036 Raw right glitch high for 3 cycles, then low -> no event; hard unchanged.
REQ-037 Press enter and right on the same cycle -> FSM=REQ, start_req=1 at edge 7, hard unchanged.
  - start_ack pulse -> start_req=0, FSM=RUN.
  - Later presses of left/right are ignored.
  - menu_return -> FSM=SEL, up=0, hard/speed retained.
REQ-038 Drop rst low while in REQ with a button held -> all outputs at reset values immediately; no event until the button has been stable for 4 cycles after release of rst.
